// File: rtl/valu_op_sequencer.sv
// Multi-cycle sequencer in front of the combinational vector ALU; builds slide-by-N from single slides.
// Optional macro VSEQ_PERF_CNT_EN adds the perf_exec_cycles EXEC-cycle counter output.

module valu_seq_lane #(
  parameter int SEW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld_cmd,
  input  logic           ld_alu,
  input  logic [SEW-1:0] vb_elem,
  input  logic [SEW-1:0] res_elem,
  output logic [SEW-1:0] work_elem
);
  always_ff @(posedge clk) begin
    if (!rst_n)      work_elem <= '0;
    else if (ld_cmd) work_elem <= vb_elem;
    else if (ld_alu) work_elem <= res_elem;
  end
endmodule

module valu_op_sequencer #(
  parameter int VL    = 8,
  parameter int SEW   = 32,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_amt,
  input  logic [SEW-1:0]    cmd_scalar,
  input  logic [VL*SEW-1:0] cmd_va,
  input  logic [VL*SEW-1:0] cmd_vb,
  output logic [3:0]        alu_operation,
  output logic              alu_is_v,
  output logic              alu_is_s,
  output logic [SEW-1:0]    alu_scalar_a,
  output logic [VL*SEW-1:0] alu_vector_a,
  output logic [VL*SEW-1:0] alu_vector_b,
  input  logic [VL*SEW-1:0] alu_result_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [VL*SEW-1:0] rsp_data,
  output logic              rsp_err
`ifdef VSEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_exec_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] OP_SLIDE1UP  = 4'd2;
  localparam logic [3:0] OP_SLIDE1DN  = 4'd3;
  localparam logic [3:0] OP_SLIDEUP_N = 4'd4;
  localparam logic [3:0] OP_SLIDEDN_N = 4'd5;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [VL*SEW-1:0]        va_q;
  logic [SEW-1:0]           fill_q;
  logic [VL-1:0][SEW-1:0]   vb_p, res_p, work_p;

  logic                     accept, illegal, slide_n;
  logic [CNT_W-1:0]         ld_cnt;
  logic [3:0]               alu_op_map;

  assign accept     = (state == IDLE) && cmd_valid;
  assign illegal    = cmd_op > OP_SLIDEDN_N;
  assign slide_n    = (cmd_op == OP_SLIDEUP_N) || (cmd_op == OP_SLIDEDN_N);
  assign ld_cnt     = slide_n ? cmd_amt : CNT_W'(1);
  // Slide-by-N reuses the single-step ALU slide each EXEC cycle.
  assign alu_op_map = (cmd_op == OP_SLIDEUP_N) ? OP_SLIDE1UP :
                      (cmd_op == OP_SLIDEDN_N) ? OP_SLIDE1DN : cmd_op;

  assign vb_p  = cmd_vb;
  assign res_p = alu_result_v;

  genvar g;
  generate
    for (g = 0; g < VL; g++) begin : g_lane
      valu_seq_lane #(.SEW(SEW)) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_cmd    (accept),
        .ld_alu    (state == EXEC),
        .vb_elem   (vb_p[g]),
        .res_elem  (res_p[g]),
        .work_elem (work_p[g])
      );
    end
  endgenerate

  assign alu_is_s     = 1'b0;
  assign alu_scalar_a = fill_q;
  assign alu_vector_a = va_q;
  assign alu_vector_b = work_p;
  assign rsp_data     = work_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      cnt           <= '0;
      va_q          <= '0;
      fill_q        <= '0;
      alu_is_v      <= 1'b0;
      alu_operation <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          va_q      <= cmd_va;
          fill_q    <= cmd_scalar;
          cnt       <= ld_cnt;
          cmd_ready <= 1'b0;
          if (illegal || ld_cnt == '0) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= illegal;
          end else begin
            state         <= EXEC;
            alu_is_v      <= 1'b1;
            alu_operation <= alu_op_map;
          end
        end
        EXEC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state         <= DONE;
            rsp_valid     <= 1'b1;
            alu_is_v      <= 1'b0;
            alu_operation <= '0;
          end
        end
        DONE: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VSEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      perf_exec_cycles <= '0;
    else if (state == EXEC && perf_exec_cycles != 32'hFFFF_FFFF)
      perf_exec_cycles <= perf_exec_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_valu_op_sequencer.sv
// Directed bench for valu_op_sequencer: ALU stand-in, queue-based response model, literal pins.
// Build with VSEQ_PERF_CNT_EN defined to also exercise the perf counter.

module tb_valu_op_sequencer;
  localparam int VL    = 8;
  localparam int SEW   = 32;
  localparam int CNT_W = 4;
  localparam int W     = VL * SEW;

  logic             clk, rst_n;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_op;
  logic [CNT_W-1:0] cmd_amt;
  logic [SEW-1:0]   cmd_scalar;
  logic [W-1:0]     cmd_va, cmd_vb;
  logic [3:0]       alu_operation;
  logic             alu_is_v, alu_is_s;
  logic [SEW-1:0]   alu_scalar_a;
  logic [W-1:0]     alu_vector_a, alu_vector_b, alu_result_v;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0]     rsp_data;
`ifdef VSEQ_PERF_CNT_EN
  logic [31:0]      perf;
`endif

  valu_op_sequencer #(.VL(VL), .SEW(SEW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_amt(cmd_amt),
    .cmd_scalar(cmd_scalar), .cmd_va(cmd_va), .cmd_vb(cmd_vb),
    .alu_operation(alu_operation), .alu_is_v(alu_is_v), .alu_is_s(alu_is_s),
    .alu_scalar_a(alu_scalar_a), .alu_vector_a(alu_vector_a), .alu_vector_b(alu_vector_b),
    .alu_result_v(alu_result_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef VSEQ_PERF_CNT_EN
    , .perf_exec_cycles(perf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational vector ALU stand-in: SUB is A-B, slides take B and the scalar fill.
  always_comb begin
    alu_result_v = '0;
    for (int i = 0; i < VL; i++) begin
      case (alu_operation)
        4'd0: alu_result_v[i*SEW +: SEW] = alu_vector_a[i*SEW +: SEW] - alu_vector_b[i*SEW +: SEW];
        4'd1: alu_result_v[i*SEW +: SEW] = alu_vector_a[i*SEW +: SEW] + alu_vector_b[i*SEW +: SEW];
        4'd2: if (i == 0) alu_result_v[i*SEW +: SEW] = alu_scalar_a;
              else        alu_result_v[i*SEW +: SEW] = alu_vector_b[(i-1)*SEW +: SEW];
        4'd3: if (i == VL-1) alu_result_v[i*SEW +: SEW] = alu_scalar_a;
              else           alu_result_v[i*SEW +: SEW] = alu_vector_b[(i+1)*SEW +: SEW];
        default: alu_result_v[i*SEW +: SEW] = '0;
      endcase
    end
  end

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] splat(input logic [SEW-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < VL; i++) r[i*SEW +: SEW] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] ramp(input logic [SEW-1:0] base);
    logic [W-1:0] r;
    for (int i = 0; i < VL; i++) r[i*SEW +: SEW] = base + SEW'(i);
    return r;
  endfunction

  // Whole-command result: element arithmetic or a direct shift by n with fill.
  function automatic logic [W-1:0] model_rsp(input logic [3:0] op, input int amt,
      input logic [SEW-1:0] fill, input logic [W-1:0] va, input logic [W-1:0] vb);
    logic [W-1:0] r;
    int n;
    bit up;
    r = vb;
    if (op == 4'd0 || op == 4'd1) begin
      for (int i = 0; i < VL; i++)
        r[i*SEW +: SEW] = (op == 4'd0) ? va[i*SEW +: SEW] - vb[i*SEW +: SEW]
                                       : va[i*SEW +: SEW] + vb[i*SEW +: SEW];
    end else if (op >= 4'd2 && op <= 4'd5) begin
      n  = (op <= 4'd3) ? 1 : amt;
      up = (op == 4'd2 || op == 4'd4);
      for (int i = 0; i < VL; i++) begin
        if (up) begin
          if (i < n) r[i*SEW +: SEW] = fill;
          else       r[i*SEW +: SEW] = vb[(i-n)*SEW +: SEW];
        end else begin
          if (i + n < VL) r[i*SEW +: SEW] = vb[(i+n)*SEW +: SEW];
          else            r[i*SEW +: SEW] = fill;
        end
      end
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input int amt);
    if (op > 4'd5) return 1;
    if (op < 4'd4) return 2;
    return (amt == 0) ? 1 : amt + 1;
  endfunction

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } exp_t;
  exp_t exp_q[$];

  // Every cycle a response is shown it must match the oldest outstanding command.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("alu_is_s", W'(alu_is_s), W'(0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_rsp: got rsp_valid=1 want 0");
        end else begin
          chk("rsp_data", rsp_data, exp_q[0].data);
          chk("rsp_err", W'(rsp_err), W'(exp_q[0].err));
          chk("cmd_ready_busy", W'(cmd_ready), W'(0));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1 with the sequencer idle; returns the first-shown response.
  task automatic do_cmd(input logic [3:0] op, input int amt, input logic [SEW-1:0] sc,
      input logic [W-1:0] va, input logic [W-1:0] vb, input int hold,
      output logic [W-1:0] got, output logic got_err);
    int lat;
    exp_t e;
    chk("cmd_ready_idle", W'(cmd_ready), W'(1));
    cmd_op = op; cmd_amt = CNT_W'(amt); cmd_scalar = sc; cmd_va = va; cmd_vb = vb;
    cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e.data = model_rsp(op, amt, sc, va, vb);
    e.err  = (op > 4'd5);
    exp_q.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    chk("latency", W'(lat), W'(model_lat(op, amt)));
    got = rsp_data;
    got_err = rsp_err;
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_va = splat(32'hDEAD); cmd_vb = splat(32'hBEEF);
        @(negedge clk);
        chk("hold_valid", W'(rsp_valid), W'(1));
        chk("hold_data", rsp_data, got);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_hs_valid", W'(rsp_valid), W'(0));
    chk("post_hs_err", W'(rsp_err), W'(0));
    chk("post_hs_ready", W'(cmd_ready), W'(1));
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] got, lit, vb;
    logic         gerr;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; cmd_scalar = '0;
    cmd_va = '0; cmd_vb = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_cmd_ready", W'(cmd_ready), W'(1));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_rsp_err", W'(rsp_err), W'(0));
    chk("rst_is_v", W'(alu_is_v), W'(0));
    chk("rst_alu_op", W'(alu_operation), W'(0));
    chk("rst_work", alu_vector_b, W'(0));
    chk("rst_va", alu_vector_a, W'(0));
    chk("rst_fill", W'(alu_scalar_a), W'(0));
`ifdef VSEQ_PERF_CNT_EN
    chk("rst_perf", W'(perf), W'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmd(4'd1, 0, '0, splat(32'd5), splat(32'd3), 0, got, gerr);
    chk("add_lit", got, splat(32'd8));
    chk("add_err", W'(gerr), W'(0));

    do_cmd(4'd0, 0, '0, ramp(32'd0), splat(32'd1), 0, got, gerr);
    lit = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF};
    chk("sub_wrap_lit", got, lit);

    do_cmd(4'd4, 3, 32'hAA, splat(32'h55), ramp(32'd0), 0, got, gerr);
    lit = {32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'hAA, 32'hAA, 32'hAA};
    chk("slideup3_lit", got, lit);

    vb = ramp(32'h100);
    do_cmd(4'd5, 0, 32'h77, splat(32'd9), vb, 0, got, gerr);
    chk("slidedn0_data", got, vb);

    do_cmd(4'd7, 2, 32'h77, splat(32'd9), vb, 0, got, gerr);
    chk("illegal7_data", got, vb);
    chk("illegal7_err", W'(gerr), W'(1));

    do_cmd(4'd2, 0, 32'hC0DE, '0, ramp(32'd10), 5, got, gerr);
    lit = {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10, 32'hC0DE};
    chk("slide1up_hold_lit", got, lit);

    do_cmd(4'd3, 0, 32'hF00D, '0, ramp(32'd20), 0, got, gerr);
    do_cmd(4'd5, 3, 32'hBB, '0, ramp(32'd0), 0, got, gerr);
    lit = {32'hBB, 32'hBB, 32'hBB, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3};
    chk("slidedn3_lit", got, lit);
    do_cmd(4'd4, 9, 32'hCC, '0, ramp(32'd0), 0, got, gerr);
    chk("slideup9_allfill", got, splat(32'hCC));
    do_cmd(4'd5, 15, 32'hDD, '0, ramp(32'd40), 0, got, gerr);
    do_cmd(4'd15, 1, 32'h0, splat(32'd1), ramp(32'd80), 2, got, gerr);

    // Abort a long slide mid-EXEC.
    cmd_op = 4'd4; cmd_amt = 4'd10; cmd_scalar = 32'hEE; cmd_vb = ramp(32'd0);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("exec_is_v", W'(alu_is_v), W'(1));
    chk("exec_alu_op", W'(alu_operation), W'(2));
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("abort_cmd_ready", W'(cmd_ready), W'(1));
    chk("abort_rsp_valid", W'(rsp_valid), W'(0));
    chk("abort_is_v", W'(alu_is_v), W'(0));
    chk("abort_work", alu_vector_b, W'(0));
`ifdef VSEQ_PERF_CNT_EN
    chk("abort_perf", W'(perf), W'(0));
`endif
    rst_n = 1'b1;
    repeat (15) @(posedge clk); #1;
    chk("abort_idle", W'(cmd_ready), W'(1));

    do_cmd(4'd4, 3, 32'hAA, splat(32'h55), ramp(32'd0), 0, got, gerr);
`ifdef VSEQ_PERF_CNT_EN
    chk("perf_after_slide3", W'(perf), W'(3));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
